// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-port signals shared by the memory port arbiter.
// Three requesters share one single-word memory port:
//   - scalar M-stage (s_*)
//   - vector M-stage (v_*)
//   - image loader (l_*)
// Handshake: a pipeline request (s_req/v_req) is held until the first cycle it
// sees stall_mem=0, which completes it and returns any load data in that cycle.
// A loader request (l_req) is held until l_gnt=1. For a loader read, l_rvalid
// pulses one cycle after l_gnt, with l_rdata valid in that cycle.
interface mem_port_arbiter_if #(
    parameter int DW     = 32,
    parameter int AW     = 16,
    parameter int VLANES = 4
);
    logic                 s_req;
    logic                 s_we;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wdata;
    logic [DW-1:0]        s_rdata;

    logic                 v_req;
    logic                 v_we;
    logic [AW-1:0]        v_addr;
    logic [VLANES*DW-1:0] v_wdata;
    logic [VLANES*DW-1:0] v_rdata;

    logic                 l_req;
    logic                 l_we;
    logic [AW-1:0]        l_addr;
    logic [DW-1:0]        l_wdata;
    logic                 l_gnt;
    logic                 l_rvalid;
    logic [DW-1:0]        l_rdata;

    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    logic                 stall_mem;

    // Arbiter view
    modport slave (
        input  s_req, s_we, s_addr, s_wdata,
        output s_rdata,
        input  v_req, v_we, v_addr, v_wdata,
        output v_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output stall_mem
    );

    // Requester / memory view
    modport master (
        output s_req, s_we, s_addr, s_wdata,
        input  s_rdata,
        output v_req, v_we, v_addr, v_wdata,
        input  v_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for one shared single-word memory port.
//   - Priority: scalar M-stage, then vector M-stage, then image loader.
//   - Vector accesses are split into VLANES single-word beats.
//   - Memory read data arrives one cycle after its address.
// Optional feature: define ARB_STARVE_GUARD_EN to add a loader starvation
// guard. It forces a loader grant after STARVE_MAX waiting cycles.
// fsm_state exposes the controller state:
//   0 = IDLE, 1 = SCALAR, 2 = VBURST, 3 = LOAD.
module mem_port_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 16,
    parameter int VLANES     = 4,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        fsm_state
);
    localparam int            BW        = $clog2(VLANES);
    localparam logic [BW-1:0] LAST_BEAT = BW'(VLANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCALAR = 2'd1,
        VBURST = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    // tail_q marks the extra cycle after the last vector-load beat,
    // in which the final lane arrives.
    logic                 tail_q, tail_d;
    logic                 v_we_q;
    logic [AW-1:0]        v_addr_q;
    logic [VLANES*DW-1:0] v_wdata_q;
    logic [VLANES*DW-1:0] v_lane_q;
    logic                 s_we_q;
    logic                 l_we_q;
    logic [DW-1:0]        s_rdata_q;
    logic [AW-1:0]        mem_addr_q;
    logic [DW-1:0]        mem_wdata_q;

    logic                 issue_we;
    logic [AW-1:0]        issue_addr;
    logic [DW-1:0]        issue_wdata;
    logic                 stall;
    logic                 gnt;
    logic                 start_s;
    logic                 start_v;
    logic                 start_l;
    logic                 starve_hit;
    logic [BW-1:0]        cap_idx;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 2);
    logic [SW-1:0] starve_q;

    assign starve_hit = (starve_q == SW'(STARVE_MAX));

    // Count loader wait cycles, saturating at STARVE_MAX; a grant clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (gnt) begin
            starve_q <= '0;
        end else if (bus.l_req && !starve_hit) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Next state, port drive and stall; reset forces every output to zero
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        tail_d      = tail_q;
        issue_we    = 1'b0;
        issue_addr  = mem_addr_q;
        issue_wdata = mem_wdata_q;
        stall       = 1'b0;
        gnt         = 1'b0;
        start_s     = 1'b0;
        start_v     = 1'b0;
        start_l     = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (starve_hit && bus.l_req) begin
                        start_l     = 1'b1;
                        gnt         = 1'b1;
                        issue_we    = bus.l_we;
                        issue_addr  = bus.l_addr;
                        issue_wdata = bus.l_wdata;
                        stall       = bus.s_req | bus.v_req;
                        state_d     = LOAD;
                    end else if (bus.s_req) begin
                        start_s     = 1'b1;
                        issue_we    = bus.s_we;
                        issue_addr  = bus.s_addr;
                        issue_wdata = bus.s_wdata;
                        stall       = 1'b1;
                        state_d     = SCALAR;
                    end else if (bus.v_req) begin
                        // Beat 0 is issued straight from the inputs
                        start_v     = 1'b1;
                        issue_we    = bus.v_we;
                        issue_addr  = bus.v_addr;
                        issue_wdata = bus.v_wdata[DW-1:0];
                        stall       = 1'b1;
                        beat_d      = BW'(1);
                        tail_d      = 1'b0;
                        state_d     = VBURST;
                    end else if (bus.l_req) begin
                        start_l     = 1'b1;
                        gnt         = 1'b1;
                        issue_we    = bus.l_we;
                        issue_addr  = bus.l_addr;
                        issue_wdata = bus.l_wdata;
                        state_d     = LOAD;
                    end
                end
                SCALAR: begin
                    state_d = IDLE;
                end
                VBURST: begin
                    if (tail_q) begin
                        tail_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        issue_we    = v_we_q;
                        issue_addr  = v_addr_q + AW'(beat_q);
                        issue_wdata = v_wdata_q[int'(beat_q)*DW +: DW];
                        if (beat_q == LAST_BEAT) begin
                            beat_d = '0;
                            stall  = !v_we_q;
                            if (v_we_q) begin
                                state_d = IDLE;
                            end else begin
                                tail_d = 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                            stall  = 1'b1;
                        end
                    end
                    stall = stall | bus.s_req;
                end
                LOAD: begin
                    state_d = IDLE;
                    stall   = bus.s_req | bus.v_req;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, beat counter and last-driven port values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            tail_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            tail_q      <= tail_d;
            mem_addr_q  <= issue_addr;
            mem_wdata_q <= issue_wdata;
        end
    end

    // Lane that the current mem_rdata belongs to during a vector load
    assign cap_idx = tail_q ? LAST_BEAT : (beat_q - 1'b1);

    // Request capture and read-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_we_q    <= 1'b0;
            v_addr_q  <= '0;
            v_wdata_q <= '0;
            v_lane_q  <= '0;
            s_we_q    <= 1'b0;
            l_we_q    <= 1'b0;
            s_rdata_q <= '0;
        end else begin
            if (start_s) begin
                s_we_q <= bus.s_we;
            end
            if (start_l) begin
                l_we_q <= bus.l_we;
            end
            if (start_v) begin
                v_we_q    <= bus.v_we;
                v_addr_q  <= bus.v_addr;
                v_wdata_q <= bus.v_wdata;
            end
            if (state_q == SCALAR && !s_we_q) begin
                s_rdata_q <= bus.mem_rdata;
            end
            if (state_q == VBURST && !v_we_q) begin
                v_lane_q[int'(cap_idx)*DW +: DW] <= bus.mem_rdata;
            end
        end
    end

    // Final vector lane is forwarded so v_rdata is whole in the unstalled cycle
    always_comb begin
        bus.v_rdata = v_lane_q;
        if (state_q == VBURST && tail_q) begin
            bus.v_rdata[(VLANES-1)*DW +: DW] = bus.mem_rdata;
        end
    end

    assign bus.s_rdata   = (state_q == SCALAR && !s_we_q) ? bus.mem_rdata : s_rdata_q;
    assign bus.l_rvalid  = (state_q == LOAD) && !l_we_q;
    assign bus.l_rdata   = bus.l_rvalid ? bus.mem_rdata : '0;
    assign bus.l_gnt     = gnt;
    assign bus.mem_we    = issue_we;
    assign bus.mem_addr  = issue_addr;
    assign bus.mem_wdata = issue_wdata;
    assign bus.stall_mem = stall;
    assign fsm_state     = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// Structure:
//   - Synchronous RAM model with one-cycle read latency.
//   - Driver tasks for the pipeline and loader requesters.
//   - Expected-response queues, filled when requests are issued.
//   - A negedge monitor that pops and compares on each completed load.
module tb_mem_port_arbiter;
    localparam int DW         = 32;
    localparam int AW         = 16;
    localparam int VLANES     = 4;
    localparam int STARVE_MAX = 15;
    localparam int VW         = VLANES * DW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] fsm_state;

    mem_port_arbiter_if #(.DW(DW), .AW(AW), .VLANES(VLANES)) bus ();

    mem_port_arbiter #(
        .DW(DW), .AW(AW), .VLANES(VLANES), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory model: write and one-cycle registered read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Scoreboard
    logic [DW-1:0] s_exp_q[$];
    logic [VW-1:0] v_exp_q[$];
    logic [DW-1:0] l_exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            stall_cnt;
    logic [AW-1:0] addr_log[$];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare completed loads against the expected queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.s_req && !bus.stall_mem) begin
                if (!bus.s_we) begin
                    if (s_exp_q.size() == 0) check("s_unexpected", 1, 0);
                    else check("s_rdata", bus.s_rdata, s_exp_q.pop_front());
                end
            end else if (bus.v_req && !bus.stall_mem && !bus.v_we) begin
                if (v_exp_q.size() == 0) check("v_unexpected", 1, 0);
                else check("v_rdata", bus.v_rdata, v_exp_q.pop_front());
            end
            if (bus.l_rvalid) begin
                if (l_exp_q.size() == 0) check("l_unexpected", 1, 0);
                else check("l_rdata", bus.l_rdata, l_exp_q.pop_front());
            end
        end
    end

    // Pipeline request; holds until stall_mem drops.
    // Records the stall count and mem_addr for each cycle of the request.
    task automatic pipe_op(input bit vec, input bit we, input logic [AW-1:0] addr,
                           input logic [VW-1:0] wdata, input bit corrupt);
        bit done = 0;
        @(posedge clk); #1;
        stall_cnt = 0;
        addr_log.delete();
        if (vec) begin
            bus.v_req = 1'b1; bus.v_we = we; bus.v_addr = addr; bus.v_wdata = wdata;
        end else begin
            bus.s_req = 1'b1; bus.s_we = we; bus.s_addr = addr; bus.s_wdata = wdata[DW-1:0];
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            addr_log.push_back(bus.mem_addr);
            if (!bus.stall_mem) begin
                done = 1;
                break;
            end
            stall_cnt++;
            if (c == 0 && corrupt) begin
                @(posedge clk); #1;
                bus.v_addr  = ~addr;
                bus.v_wdata = ~wdata;
            end
        end
        check("pipe_done", done, 1);
        @(posedge clk); #1;
        bus.s_req = 1'b0;
        bus.v_req = 1'b0;
    endtask

    // Loader request; holds until granted, then waits out the response cycle
    task automatic l_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bit got = 0;
        @(posedge clk); #1;
        bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.l_gnt) begin
                got = 1;
                break;
            end
        end
        check("l_op_gnt", got, 1);
        @(posedge clk); #1;
        bus.l_req = 1'b0;
        @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        bit got;
        int gcyc;
        bus.s_req = 0; bus.s_we = 0; bus.s_addr = '0; bus.s_wdata = '0;
        bus.v_req = 0; bus.v_we = 0; bus.v_addr = '0; bus.v_wdata = '0;
        bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0020] = 32'h0000C0DE;
        mem[16'hFFFE] = 32'hAAAA0000;
        mem[16'hFFFF] = 32'hBBBB0001;
        mem[16'h0000] = 32'hCCCC0002;
        mem[16'h0001] = 32'hDDDD0003;

        // Reset state
        #3;
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_stall", bus.stall_mem, 0);
        check("rst_l_gnt", bus.l_gnt, 0);
        check("rst_l_rvalid", bus.l_rvalid, 0);
        check("rst_l_rdata", bus.l_rdata, 0);
        check("rst_s_rdata", bus.s_rdata, 0);
        check("rst_v_rdata", bus.v_rdata, 0);
        check("rst_state", fsm_state, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Scalar load: one stall cycle, data then held
        s_exp_q.push_back(32'hDEADBEEF);
        pipe_op(0, 0, 16'h0010, '0, 0);
        check("scalar_stall_cycles", stall_cnt, 1);
        @(negedge clk);
        check("scalar_rdata_held", bus.s_rdata, 32'hDEADBEEF);

        // Vector load across the address wrap
        v_exp_q.push_back({32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000});
        pipe_op(1, 0, 16'hFFFE, '0, 0);
        check("vload_stall_cycles", stall_cnt, 4);
        check("vload_log_len", addr_log.size(), 5);
        if (addr_log.size() >= 4) begin
            check("vload_addr0", addr_log[0], 16'hFFFE);
            check("vload_addr1", addr_log[1], 16'hFFFF);
            check("vload_addr2", addr_log[2], 16'h0000);
            check("vload_addr3", addr_log[3], 16'h0001);
        end

        // Vector store with inputs disturbed mid-burst, then read-back
        pipe_op(1, 1, 16'h0100, {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001}, 1);
        check("vstore_stall_cycles", stall_cnt, 3);
        check("vstore_log_len", addr_log.size(), 4);
        if (addr_log.size() >= 4) begin
            check("vstore_addr0", addr_log[0], 16'h0100);
            check("vstore_addr3", addr_log[3], 16'h0103);
        end
        s_exp_q.push_back(32'h33330003);
        pipe_op(0, 0, 16'h0102, '0, 0);
        s_exp_q.push_back(32'h44440004);
        pipe_op(0, 0, 16'h0103, '0, 0);
        s_exp_q.push_back(32'h11110001);
        pipe_op(0, 0, 16'h0100, '0, 0);

        // Loader write then scalar read-back; loader read
        l_op(1, 16'h0030, 32'h12345678);
        s_exp_q.push_back(32'h12345678);
        pipe_op(0, 0, 16'h0030, '0, 0);
        l_exp_q.push_back(32'h12345678);
        l_op(0, 16'h0030, '0);

        // Scalar and loader together: scalar first, loader right after
        @(posedge clk); #1;
        s_exp_q.push_back(32'h0000C0DE);
        l_exp_q.push_back(32'hDEADBEEF);
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = 16'h0010;
        bus.s_req = 1; bus.s_we = 0; bus.s_addr = 16'h0020;
        @(negedge clk);
        check("sl_c0_gnt", bus.l_gnt, 0);
        check("sl_c0_stall", bus.stall_mem, 1);
        @(negedge clk);
        check("sl_c1_gnt", bus.l_gnt, 0);
        check("sl_c1_stall", bus.stall_mem, 0);
        @(posedge clk); #1;
        bus.s_req = 0;
        @(negedge clk);
        check("sl_c2_gnt", bus.l_gnt, 1);
        @(posedge clk); #1;
        bus.l_req = 0;
        @(negedge clk);
        check("sl_rvalid", bus.l_rvalid, 1);

        // Scalar stores held for 20 cycles against a waiting loader store
        @(posedge clk); #1;
        got = 0;
        gcyc = -1;
        bus.s_req = 1; bus.s_we = 1; bus.s_addr = 16'h0300; bus.s_wdata = 32'h0BAD0BAD;
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = 16'h0301; bus.l_wdata = 32'h0000F00D;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.l_gnt && !got) begin
                got = 1;
                gcyc = i;
            end
            @(posedge clk); #1;
            if (got) bus.l_req = 0;
        end
        bus.s_req = 0;
        bus.l_req = 0;
`ifdef ARB_STARVE_GUARD_EN
        check("starve_gnt_seen", got, 1);
        check("starve_gnt_by_16", (gcyc >= 0 && gcyc <= STARVE_MAX + 1), 1);
`else
        check("starve_no_gnt", got, 0);
`endif
        repeat (3) @(posedge clk);

        // Reset during beat 2 of a vector store
        @(posedge clk); #1;
        bus.v_req = 1; bus.v_we = 1; bus.v_addr = 16'h0200;
        bus.v_wdata = {32'h00A30003, 32'h00A20002, 32'h00A10001, 32'h00A00000};
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rb_beat2_we", bus.mem_we, 1);
        check("rb_beat2_addr", bus.mem_addr, 16'h0202);
        check("rb_beat2_wdata", bus.mem_wdata, 32'h00A20002);
        #1;
        rst_n = 0;
        bus.v_req = 0;
        #1;
        check("rb_in_rst_we", bus.mem_we, 0);
        check("rb_in_rst_stall", bus.stall_mem, 0);
        check("rb_in_rst_state", fsm_state, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("rb_after_we", bus.mem_we, 0);
        check("rb_after_stall", bus.stall_mem, 0);
        check("rb_after_state", fsm_state, 0);
        s_exp_q.push_back(32'h00A10001);
        pipe_op(0, 0, 16'h0201, '0, 0);
        s_exp_q.push_back(32'h00000000);
        pipe_op(0, 0, 16'h0202, '0, 0);

        repeat (3) @(posedge clk);
        check("s_exp_drained", s_exp_q.size(), 0);
        check("v_exp_drained", v_exp_q.size(), 0);
        check("l_exp_drained", l_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
